// File: rtl/tis_pkg.sv
// rtl/tis_pkg.sv - opcodes, selector offsets and FSM encoding shared by the TIS node datapath
package tis_pkg;

  // Instruction opcodes presented by the node control unit
  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NEG = 3'd3;
  localparam logic [2:0] OP_SWP = 3'd4;
  localparam logic [2:0] OP_SAV = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  // Non-port operand selectors sit directly above the port range: value = N_PORTS + offset
  localparam int SEL_ACC = 0;
  localparam int SEL_IMM = 1;
  localparam int SEL_BAK = 2;
  localparam int SEL_NIL = 3;

  // ALU function select
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_NEG = 2'd2;

  // EXEC runs instructions; OUT_WAIT holds an outbound word until the neighbour takes it
  typedef enum logic {
    ST_EXEC     = 1'b0,
    ST_OUT_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/tis_alu.sv
// rtl/tis_alu.sv - combinational ADD/SUB/NEG for the TIS node; saturates when TIS_DP_SAT_EN is defined
module tis_alu
  import tis_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

`ifdef TIS_DP_SAT_EN
  // One extra bit holds every ADD/SUB/NEG result exactly before clamping
  localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-2){1'b0}}, 1'b1};

  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;
  logic signed [DATA_W:0] wide;

  assign a_x = {a[DATA_W-1], a};
  assign b_x = {b[DATA_W-1], b};

  // Widened arithmetic, then clamp symmetrically so the most negative code never appears
  always_comb begin
    case (alu_op)
      ALU_ADD: wide = a_x + b_x;
      ALU_SUB: wide = a_x - b_x;
      ALU_NEG: wide = '0 - a_x;
      default: wide = a_x;
    endcase
    if (wide > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (wide < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end else begin
      result = wide[DATA_W-1:0];
    end
  end
`else
  // Plain two's-complement arithmetic wrapping modulo 2^DATA_W
  always_comb begin
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NEG: result = '0 - a;
      default: result = a;
    endcase
  end
`endif

endmodule

// File: rtl/tis_node_dp.sv
// rtl/tis_node_dp.sv - TIS node execution datapath with blocking neighbour ports; optional TIS_DP_SAT_EN saturation
module tis_node_dp
  import tis_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 4,
  parameter int SEL_W   = $clog2(N_PORTS + 4)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  input  logic [2:0]                op_code,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [SEL_W-1:0]          dst_sel,
  input  logic [DATA_W-1:0]         imm,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_valid,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [N_PORTS*DATA_W-1:0] out_data,
  output logic [N_PORTS-1:0]        out_valid,
  input  logic [N_PORTS-1:0]        out_ready,
  output logic                      stall,
  output logic                      retire,
  output logic [DATA_W-1:0]         acc,
  output logic                      acc_zero,
  output logic                      acc_neg
);

  localparam logic [SEL_W-1:0] S_NPORTS = SEL_W'(N_PORTS);
  localparam logic [SEL_W-1:0] S_ACC    = SEL_W'(N_PORTS + SEL_ACC);
  localparam logic [SEL_W-1:0] S_IMM    = SEL_W'(N_PORTS + SEL_IMM);
  localparam logic [SEL_W-1:0] S_BAK    = SEL_W'(N_PORTS + SEL_BAK);

  state_t                      state_q;
  logic [DATA_W-1:0]           acc_q;
  logic [DATA_W-1:0]           bak_q;
  logic [N_PORTS*DATA_W-1:0]   out_data_q;
  logic [N_PORTS-1:0]          out_valid_q;

  logic [DATA_W-1:0]           src_val;
  logic                        src_avail;
  logic                        uses_src;
  logic                        src_ok;
  logic                        mov_to_port;
  logic                        exec_fire;
  logic                        out_hs;
  logic [1:0]                  alu_op;
  logic [DATA_W-1:0]           alu_res;

  // Source operand mux; NIL and unused selector codes read as zero
  always_comb begin
    src_val   = '0;
    src_avail = 1'b1;
    for (int k = 0; k < N_PORTS; k++) begin
      if (src_sel == SEL_W'(k)) begin
        src_val   = in_data[k*DATA_W +: DATA_W];
        src_avail = in_valid[k];
      end
    end
    if (src_sel == S_ACC) begin
      src_val = acc_q;
    end else if (src_sel == S_IMM) begin
      src_val = imm;
    end else if (src_sel == S_BAK) begin
      src_val = bak_q;
    end
  end

  // Instruction decode: only MOV/ADD/SUB read src, so only they can block on an empty port
  always_comb begin
    uses_src    = (op_code == OP_MOV) || (op_code == OP_ADD) || (op_code == OP_SUB);
    src_ok      = !uses_src || src_avail;
    mov_to_port = (op_code == OP_MOV) && (dst_sel < S_NPORTS);
    exec_fire   = rst_n && (state_q == ST_EXEC) && op_valid && src_ok;
    out_hs      = |(out_valid_q & out_ready);
    case (op_code)
      OP_SUB:  alu_op = ALU_SUB;
      OP_NEG:  alu_op = ALU_NEG;
      default: alu_op = ALU_ADD;
    endcase
  end

  // Consume strobe to the source port in the cycle the instruction fires
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (exec_fire && uses_src && (src_sel == SEL_W'(k))) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  // A port-destination MOV retires on the outbound handshake, everything else retires on firing
  always_comb begin
    retire = rst_n && ((exec_fire && !mov_to_port) || ((state_q == ST_OUT_WAIT) && out_hs));
    stall  = op_valid && !retire;
  end

  tis_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .alu_op (alu_op),
    .a      (acc_q),
    .b      (src_val),
    .result (alu_res)
  );

  // Execution FSM with ACC/BAK and outbound port registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EXEC;
      acc_q       <= '0;
      bak_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          if (exec_fire) begin
            if (mov_to_port) begin
              for (int k = 0; k < N_PORTS; k++) begin
                if (dst_sel == SEL_W'(k)) begin
                  out_data_q[k*DATA_W +: DATA_W] <= src_val;
                  out_valid_q[k]                 <= 1'b1;
                end
              end
              state_q <= ST_OUT_WAIT;
            end else begin
              case (op_code)
                OP_MOV: begin
                  if (dst_sel == S_ACC) begin
                    acc_q <= src_val;
                  end else if (dst_sel == S_BAK) begin
                    bak_q <= src_val;
                  end
                end
                OP_ADD, OP_SUB, OP_NEG: acc_q <= alu_res;
                OP_SWP: begin
                  acc_q <= bak_q;
                  bak_q <= acc_q;
                end
                OP_SAV: bak_q <= acc_q;
                default: ;
              endcase
            end
          end
        end
        ST_OUT_WAIT: begin
          if (out_hs) begin
            out_valid_q <= '0;
            state_q     <= ST_EXEC;
          end
        end
        default: state_q <= ST_EXEC;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign acc_zero  = (acc_q == '0);
  assign acc_neg   = acc_q[DATA_W-1];

  // The control unit must keep the instruction presented until the outbound word is taken
  a_hold_op_in_out_wait : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_OUT_WAIT) |-> op_valid);

  // At most one outbound word is ever pending
  a_single_out_valid : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(out_valid_q));

endmodule

// File: tb/tb_tis_node_dp.sv
// tb/tb_tis_node_dp.sv - randomized scoreboard bench for tis_node_dp
module tb_tis_node_dp;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int SW = 3;
  localparam logic [SW-1:0] S_ACC = 3'd4;
  localparam logic [SW-1:0] S_IMM = 3'd5;
  localparam logic [SW-1:0] S_BAK = 3'd6;
  localparam logic [SW-1:0] S_NIL = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_valid = 1'b0;
  logic [2:0]        op_code = 3'd0;
  logic [SW-1:0]     src_sel = '0;
  logic [SW-1:0]     dst_sel = '0;
  logic [DW-1:0]     imm = '0;
  logic [NP*DW-1:0]  in_data = '0;
  logic [NP-1:0]     in_valid = '0;
  logic [NP-1:0]     in_ready;
  logic [NP*DW-1:0]  out_data;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready = '0;
  logic              stall;
  logic              retire;
  logic [DW-1:0]     acc;
  logic              acc_zero;
  logic              acc_neg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] acc_after;
    int            out_port;
    logic [DW-1:0] out_word;
    logic [NP-1:0] cons;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] m_acc = '0;
  logic [DW-1:0] m_bak = '0;

  always #5 clk = ~clk;

  tis_node_dp #(.DATA_W(DW), .N_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .src_sel(src_sel), .dst_sel(dst_sel), .imm(imm),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .stall(stall), .retire(retire), .acc(acc), .acc_zero(acc_zero), .acc_neg(acc_neg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Signed result of an ALU op as the ISA defines it
  function automatic logic [DW-1:0] arith(input int r);
    int v;
    v = r;
`ifdef TIS_DP_SAT_EN
    if (v > 127) v = 127;
    if (v < -127) v = -127;
`endif
    return DW'(v);
  endfunction

  // Reference model: apply one instruction to ACC/BAK and queue what the DUT must show
  task automatic model_push(input logic [2:0] op, input logic [SW-1:0] s, input logic [SW-1:0] d,
                            input logic [DW-1:0] im, input logic [DW-1:0] word);
    exp_t e;
    logic [DW-1:0] sv;
    logic [DW-1:0] tmp;
    int sp, dp;
    bit uses;
    sp = int'(s);
    dp = int'(d);
    if (sp < NP) sv = word;
    else if (s == S_ACC) sv = m_acc;
    else if (s == S_IMM) sv = im;
    else if (s == S_BAK) sv = m_bak;
    else sv = '0;
    uses = (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
    e.cons = '0;
    if (uses && sp < NP) e.cons[sp] = 1'b1;
    e.out_port = -1;
    e.out_word = '0;
    case (op)
      3'd0: begin
        if (dp < NP) begin
          e.out_port = dp;
          e.out_word = sv;
        end else if (d == S_ACC) m_acc = sv;
        else if (d == S_BAK) m_bak = sv;
      end
      3'd1: m_acc = arith(int'($signed(m_acc)) + int'($signed(sv)));
      3'd2: m_acc = arith(int'($signed(m_acc)) - int'($signed(sv)));
      3'd3: m_acc = arith(-int'($signed(m_acc)));
      3'd4: begin
        tmp = m_acc;
        m_acc = m_bak;
        m_bak = tmp;
      end
      3'd5: m_bak = m_acc;
      default: ;
    endcase
    e.acc_after = m_acc;
    sbq.push_back(e);
  endtask

  // Present one instruction and play both neighbours until it retires
  task automatic issue(input logic [2:0] op, input logic [SW-1:0] s, input logic [SW-1:0] d,
                       input logic [DW-1:0] im, input int in_dly, input int out_dly, input int force_word,
                       output int cycles, output int stalls, output int pulses);
    logic [DW-1:0] word;
    bit consumed;
    bit done;
    int sp;
    sp = int'(s);
    word = (force_word >= 0) ? DW'(force_word) : DW'($urandom);
    model_push(op, s, d, im, word);
    in_data  = $urandom;
    in_valid = NP'($urandom);
    if (sp < NP) in_valid[sp] = 1'b0;
    op_code  = op;
    src_sel  = s;
    dst_sel  = d;
    imm      = im;
    op_valid = 1'b1;
    cycles = 0; stalls = 0; pulses = 0; consumed = 0; done = 0;
    while (!done) begin
      if (sp < NP && !consumed && cycles >= in_dly) begin
        in_valid[sp] = 1'b1;
        in_data[sp*DW +: DW] = word;
      end
      out_ready = (cycles >= out_dly) ? '1 : '0;
      @(negedge clk);
      if (stall) stalls++;
      if (in_ready != '0) pulses++;
      if (sp < NP && in_ready[sp]) consumed = 1;
      if (retire) done = 1;
      cycles++;
      @(posedge clk);
      #1;
      if (consumed) in_valid = '0;
      if (!done && cycles > 60) begin
        check("issue_timeout", 32'(cycles), 32'd0);
        done = 1;
      end
    end
    op_valid  = 1'b0;
    in_valid  = '0;
    out_ready = '0;
  endtask

  // Idle cycles with op_valid low and junk on every other input
  task automatic idle(input int n);
    repeat (n) begin
      op_valid = 1'b0;
      op_code  = 3'($urandom);
      src_sel  = SW'($urandom);
      dst_sel  = SW'($urandom);
      in_valid = NP'($urandom);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    in_valid = '0;
  endtask

  // Scoreboard monitor: every retire pops one expected result
  logic [NP-1:0] seen = '0;
  logic          pend = 1'b0;
  logic [DW-1:0] pend_acc = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    logic [NP-1:0] cur;
    if (!rst_n) begin
      seen <= '0;
      pend <= 1'b0;
    end else begin
      if (pend) begin
        check("acc", 32'(acc), 32'(pend_acc));
        check("acc_zero", 32'(acc_zero), 32'(pend_acc == '0));
        check("acc_neg", 32'(acc_neg), 32'(pend_acc[DW-1]));
      end
      if (!op_valid) check("idle_in_ready", 32'(in_ready), 32'd0);
      cur = seen | in_ready;
      if (retire) begin
        if (sbq.size() == 0) begin
          check("unexpected_retire", 32'(retire), 32'd0);
          seen <= '0;
          pend <= 1'b0;
        end else begin
          e = sbq.pop_front();
          check("consume_mask", 32'(cur), 32'(e.cons));
          if (e.out_port >= 0) begin
            check("out_valid", 32'(out_valid), 32'(1 << e.out_port));
            check("out_data", 32'(out_data[e.out_port*DW +: DW]), 32'(e.out_word));
          end
          seen     <= '0;
          pend     <= 1'b1;
          pend_acc <= e.acc_after;
        end
      end else begin
        seen <= cur;
        pend <= 1'b0;
      end
    end
  end

  initial begin : stim
    int cyc, stl, pls;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_acc_zero", 32'(acc_zero), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MOV IMM=5 -> ACC retires in its own cycle
    issue(3'd0, S_IMM, S_ACC, 8'd5, 0, 0, -1, cyc, stl, pls);
    check("mov_imm_cycles", 32'(cyc), 32'd1);
    check("mov_imm_acc", 32'(acc), 32'd5);
    check("mov_imm_zero", 32'(acc_zero), 32'd0);

    // MOV port2 -> ACC with data arriving after 3 cycles
    issue(3'd0, 3'd2, S_ACC, 8'd0, 3, 0, 8'h12, cyc, stl, pls);
    check("port_wait_cycles", 32'(cyc), 32'd4);
    check("port_wait_stalls", 32'(stl), 32'd3);
    check("port_wait_pulses", 32'(pls), 32'd1);
    check("port_wait_acc", 32'(acc), 32'h12);

    // MOV IMM=7 -> port1 with the neighbour busy for 4 cycles
    issue(3'd0, S_IMM, 3'd1, 8'd7, 0, 4, -1, cyc, stl, pls);
    check("out_wait_cycles", 32'(cyc), 32'd5);
    check("out_wait_stalls", 32'(stl), 32'd4);
    check("out_wait_cleared", 32'(out_valid), 32'd0);

    // Minimum port-to-port latency
    issue(3'd0, 3'd3, 3'd0, 8'd0, 0, 0, -1, cyc, stl, pls);
    check("p2p_latency", 32'(cyc), 32'd2);

    // ACC=3, SAV, ADD 4, SWP, NEG, then read BAK back
    issue(3'd0, S_IMM, S_ACC, 8'd3, 0, 0, -1, cyc, stl, pls);
    issue(3'd5, S_NIL, S_NIL, 8'd0, 0, 0, -1, cyc, stl, pls);
    issue(3'd1, S_IMM, S_NIL, 8'd4, 0, 0, -1, cyc, stl, pls);
    issue(3'd4, 3'd0, S_NIL, 8'd0, 0, 0, -1, cyc, stl, pls);
    check("swp_acc", 32'(acc), 32'd3);
    issue(3'd3, 3'd1, S_NIL, 8'd0, 0, 0, -1, cyc, stl, pls);
    check("neg_acc", 32'(acc), 32'hFD);
    check("neg_flag", 32'(acc_neg), 32'd1);
    issue(3'd0, S_BAK, S_ACC, 8'd0, 0, 0, -1, cyc, stl, pls);
    check("bak_readback", 32'(acc), 32'd7);

    // 100 + 100
    issue(3'd0, S_IMM, S_ACC, 8'd100, 0, 0, -1, cyc, stl, pls);
    issue(3'd1, S_IMM, S_ACC, 8'd100, 0, 0, -1, cyc, stl, pls);
`ifdef TIS_DP_SAT_EN
    check("add_overflow", 32'(acc), 32'h7F);
`else
    check("add_overflow", 32'(acc), 32'hC8);
`endif

    // Reset while an outbound word is pending
    op_code = 3'd0; src_sel = S_IMM; dst_sel = 3'd1; imm = 8'd9; op_valid = 1'b1; out_ready = '0;
    @(negedge clk);
    check("rst_mid_exec_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_pending", 32'(out_valid), 32'b0010);
    check("rst_mid_data", 32'(out_data[1*DW +: DW]), 32'd9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = '0;
    m_bak = '0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_acc", 32'(acc), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    issue(3'd0, S_IMM, S_ACC, 8'd1, 0, 0, -1, cyc, stl, pls);
    check("rst_mid_exec", 32'(cyc), 32'd1);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom), SW'($urandom), SW'($urandom), DW'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, cyc, stl, pls);
      idle(int'($urandom_range(0, 2)));
    end

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tis_node_dp.md
Name: tis_node_dp

Overview:
- Parametrised next-generation execution datapath for one TIS node: ACC/BAK registers, ALU, and N_PORTS blocking neighbour ports with valid/ready handshakes.
- Executes one issued instruction at a time from the node control unit.
- Stalls the control unit on unavailable input data and on unconsumed output data (TIS blocking-port semantics).
- Exposes ACC and condition flags for JEZ/JNZ/JGZ/JLZ evaluation in the control unit.

Parameters:
- DATA_W, 8, datapath width in bits; two's-complement signed.
- N_PORTS, 4, number of neighbour port pairs, 1..8.
- SEL_W, $clog2(N_PORTS+4), operand selector width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- op_valid  in  1  instruction presented; fields held stable while stall=1.
- op_code  in  3  0 MOV, 1 ADD, 2 SUB, 3 NEG, 4 SWP, 5 SAV, 6 NOP, 7 reserved (treated as NOP).
- src_sel  in  SEL_W  0..N_PORTS-1 port; N_PORTS ACC; +1 IMM; +2 BAK; +3 NIL.
- dst_sel  in  SEL_W  same encoding; IMM as destination is treated as NIL.
- imm  in  DATA_W  immediate operand.
- in_data  in  N_PORTS*DATA_W  packed inbound words; port k at [k*DATA_W +: DATA_W].
- in_valid  in  N_PORTS  inbound word valid.
- in_ready  out  N_PORTS  inbound consume strobe.
- out_data  out  N_PORTS*DATA_W  registered outbound words.
- out_valid  out  N_PORTS  outbound word pending.
- out_ready  in  N_PORTS  neighbour consumes outbound word.
- stall  out  1  op_valid && !retire.
- retire  out  1  instruction completes this cycle.
- acc  out  DATA_W  ACC value.
- acc_zero, acc_neg  out  1 each  ACC==0; ACC[DATA_W-1].

Behaviour:
- Reset (synchronous, rst_n=0):
  - ACC=0, BAK=0, all out_data=0, out_valid=0, in_ready=0, state=EXEC.
  - Reset mid-handshake discards the pending output word.
- FSM states: EXEC, OUT_WAIT.
- Source availability in EXEC: src_ok = 1 unless src is port k with in_valid[k]=0.
- EXEC with op_valid, src_ok and no port destination:
  - retire=1 the same cycle.
  - Register updates land at that clock edge.
  - in_ready[k]=1 the same cycle if src is port k.
- MOV to port d (EXEC, op_valid, src_ok):
  - out_data[d]<=src, out_valid[d]<=1, source consumed, go to OUT_WAIT.
  - stall=1 in the EXEC cycle.
- OUT_WAIT:
  - retire=1 in the cycle out_valid[d]&&out_ready[d]; out_valid[d]<=0 at that edge; return to EXEC.
  - Latency of port-to-port MOV is 2 cycles minimum.
- Register operations:
  - MOV to ACC or BAK: write src.
  - ADD: ACC<=ACC+src.
  - SUB: ACC<=ACC-src.
  - NEG: ACC<=0-ACC.
  - SWP: ACC<=BAK and BAK<=ACC at one edge.
  - SAV: BAK<=ACC.
  - NOP: no register change.
  - NIL as destination: result dropped, but port source is still consumed.
  - NIL as source reads 0.
- Source dependency: ADD/SUB/MOV with a port source block until that port is valid. NEG, SWP, SAV and NOP ignore src_sel and never block.
- Arithmetic wraps modulo 2^DATA_W unless TIS_DP_SAT_EN is defined.
- Same port k as source and destination is legal; they are independent directions.
- in_ready is never asserted when op_valid=0.
- op_valid dropped in EXEC: no side effects.
- op_valid dropped in OUT_WAIT: illegal (assertion); the FSM still completes the handshake.
- Only one out_valid bit is ever set at a time.

Optional Feature:
- Macro: TIS_DP_SAT_EN.
- Defined:
  - ADD/SUB/NEG results are clamped to [-(2^(DATA_W-1)-1), +(2^(DATA_W-1)-1)].
  - Clamping uses a DATA_W+1 intermediate.
  - For DATA_W=8: 100+100 gives 127; -128 is never produced.
- Not defined: plain modulo-2^DATA_W wrap (100+100 gives -56).

Decomposition:
- Package tis_pkg:
  - op_code localparams OP_MOV..OP_NOP.
  - Selector offset constants SEL_ACC/SEL_IMM/SEL_BAK/SEL_NIL, expressed relative to N_PORTS.
  - FSM state encoding.
- Sub-module tis_alu, parametrised on DATA_W:
  - Combinational ADD/SUB/NEG.
  - Contains the saturation logic under TIS_DP_SAT_EN.

Test Plan:
- Reset then MOV IMM=5 to ACC -> retire same cycle; acc=5 next cycle, acc_zero=0.
- MOV port2 to ACC with in_valid[2] low for 3 cycles, then data=0x12 -> stall=1 for 3 cycles; in_ready[2] pulses once; acc=0x12.
- MOV IMM=7 to port1, out_ready[1] low 4 cycles -> out_valid[1]=1 and out_data[1]=7 held; retire on the ready cycle; out_valid[1]=0 next.
- ACC=3, SAV, ADD IMM=4, SWP -> BAK=7, ACC=3 after SWP; NEG gives acc=0xFD, acc_neg=1.
- ACC=100, ADD IMM=100 -> acc=0x7F with TIS_DP_SAT_EN; 0xC8 without.
- rst_n low during OUT_WAIT -> next cycle out_valid=0, ACC=0, state EXEC, stall=0.
